// File: rtl/present_ctrl_pkg.sv
// Shared widths and state encoding for the PRESENT-80 job arbiter.
package present_ctrl_pkg;
  localparam int KEY_W     = 80;
  localparam int BLK_W     = 64;
  localparam int NUM_REQ   = 2;
  localparam int REQ_IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: a lone requester always wins; on contention the
// requester that was not granted last time wins.
module rr_arb2
  import present_ctrl_pkg::*;
(
  input  logic [NUM_REQ-1:0]   req,
  input  logic [REQ_IDX_W-1:0] last_gnt,
  output logic                 gnt_valid,
  output logic [REQ_IDX_W-1:0] gnt_idx
);

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = '0;
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last_gnt;
      default: gnt_idx = '0;
    endcase
  end

endmodule

// File: rtl/present_job_arbiter.sv
// Shares one present80_core between two requesters: round-robin grant, operand latching,
// start/done sequencing with a watchdog abort, and a 4-phase req/ack response.
module present_job_arbiter
  import present_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [KEY_W-1:0]   key0,
  input  logic [KEY_W-1:0]   key1,
  input  logic [BLK_W-1:0]   pt0,
  input  logic [BLK_W-1:0]   pt1,
  output logic [NUM_REQ-1:0] ack,
  output logic [BLK_W-1:0]   rsp_ct,
  output logic               rsp_err,
  output logic               busy,
  output logic               core_start,
  output logic [KEY_W-1:0]   core_key,
  output logic [BLK_W-1:0]   core_pt,
  input  logic               core_busy,
  input  logic               core_done,
  input  logic [BLK_W-1:0]   core_ct,
  output logic [CNT_W-1:0]   jobs0,
  output logic [CNT_W-1:0]   jobs1
);

  localparam int            WD_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

  state_t                 state;
  logic [REQ_IDX_W-1:0]   gnt;
  logic [REQ_IDX_W-1:0]   last_gnt;
  logic [WD_W-1:0]        wd;
  logic                   arb_vld;
  logic [REQ_IDX_W-1:0]   arb_idx;

  // core_busy is informational only; sequencing relies solely on core_done.
  logic                   core_busy_unused;
  assign core_busy_unused = core_busy;

  rr_arb2 u_arb (
    .req       (req),
    .last_gnt  (last_gnt),
    .gnt_valid (arb_vld),
    .gnt_idx   (arb_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      gnt        <= '0;
      last_gnt   <= 1'b1;
      wd         <= '0;
      ack        <= '0;
      rsp_ct     <= '0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
      core_start <= 1'b0;
      core_key   <= '0;
      core_pt    <= '0;
      jobs0      <= '0;
      jobs1      <= '0;
    end else begin
      core_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_vld) begin
            gnt        <= arb_idx;
            last_gnt   <= arb_idx;
            core_key   <= arb_idx ? key1 : key0;
            core_pt    <= arb_idx ? pt1 : pt0;
            core_start <= 1'b1;
            busy       <= 1'b1;
            state      <= ST_START;
          end
        end
        // core_done is deliberately not looked at here so a level left over
        // from the previous job cannot complete this one.
        ST_START: begin
          wd    <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (core_done) begin
            rsp_ct  <= core_ct;
            rsp_err <= 1'b0;
            ack     <= gnt ? 2'b10 : 2'b01;
            if (gnt == 1'b0) jobs0 <= jobs0 + 1'b1;
            else             jobs1 <= jobs1 + 1'b1;
            state   <= ST_RESP;
          end else if (wd == WD_MAX) begin
            rsp_ct  <= '0;
            rsp_err <= 1'b1;
            ack     <= gnt ? 2'b10 : 2'b01;
            state   <= ST_RESP;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        ST_RESP: begin
          if (!req[gnt]) begin
            ack   <= '0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          ack   <= '0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_present_job_arbiter.sv
// Self-checking bench for present_job_arbiter with a behavioural PRESENT-80 core model.
module tb_present_job_arbiter;
  localparam int TO = 64;
  localparam int CW = 4;
  localparam logic [63:0] STALE_CT = 64'hDEAD_BEEF_0123_4567;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    req = '0;
  logic [79:0]   key0 = '0, key1 = '0;
  logic [63:0]   pt0 = '0, pt1 = '0;
  logic [1:0]    ack;
  logic [63:0]   rsp_ct;
  logic          rsp_err, busy, core_start;
  logic [79:0]   core_key;
  logic [63:0]   core_pt;
  logic          core_busy, core_done;
  logic [63:0]   core_ct;
  logic [CW-1:0] jobs0, jobs1;

  int checks = 0;
  int errors = 0;
  int core_mode = 0;  // 0 reference core, 1 done stuck low, 2 done stuck high
  int core_lat  = 31;
  int m_last = 1;
  int m_jobs[2];

  present_job_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .key0(key0), .key1(key1),
    .pt0(pt0), .pt1(pt1), .ack(ack), .rsp_ct(rsp_ct), .rsp_err(rsp_err),
    .busy(busy), .core_start(core_start), .core_key(core_key), .core_pt(core_pt),
    .core_busy(core_busy), .core_done(core_done), .core_ct(core_ct),
    .jobs0(jobs0), .jobs1(jobs1)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
      4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
      4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
      4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
    endcase
  endfunction

  function automatic logic [63:0] present80(input logic [79:0] key_in, input logic [63:0] blk);
    logic [79:0] k;
    logic [63:0] s, t;
    k = key_in;
    s = blk;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[79:16];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = sbox4(s[4*n +: 4]);
      t = '0;
      for (int b = 0; b < 63; b++) t[(b * 16) % 63] = s[b];
      t[63] = s[63];
      s = t;
      k = {k[18:0], k[79:19]};
      k[79:76] = sbox4(k[79:76]);
      k[19:15] = k[19:15] ^ 5'(r);
    end
    return s ^ k[79:16];
  endfunction

  // Behavioural core: done pulses core_lat cycles after it sees core_start.
  logic        m_run;
  int          m_cnt;
  logic [63:0] m_res;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_done <= 1'b0; core_ct <= '0; core_busy <= 1'b0;
      m_run <= 1'b0; m_cnt <= 0; m_res <= '0;
    end else begin
      core_done <= 1'b0;
      if (core_mode == 2) begin
        core_done <= 1'b1;
        core_ct   <= STALE_CT;
      end else if (core_mode == 0) begin
        if (core_start) begin
          m_run <= 1'b1; m_cnt <= 1; core_busy <= 1'b1;
          m_res <= present80(core_key, core_pt);
        end else if (m_run) begin
          if (m_cnt >= core_lat) begin
            core_done <= 1'b1; core_ct <= m_res; m_run <= 1'b0; core_busy <= 1'b0;
          end else begin
            m_cnt <= m_cnt + 1;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      checks++;
      if (ack == 2'b11) begin
        errors++;
        $display("FAIL both_acks: got %b expected one-hot or zero", ack);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  function automatic int pick(input logic [1:0] r);
    if (r == 2'b11) return (m_last == 0) ? 1 : 0;
    return (r == 2'b10) ? 1 : 0;
  endfunction

  function automatic logic [79:0] rnd80();
    return {$urandom(), $urandom(), 16'($urandom())};
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    req = '0;
    @(negedge clk);
    chk("rst_ack", 80'(ack), 80'(0));
    chk("rst_busy", 80'(busy), 80'(0));
    chk("rst_start", 80'(core_start), 80'(0));
    chk("rst_ct", 80'(rsp_ct), 80'(0));
    chk("rst_err", 80'(rsp_err), 80'(0));
    chk("rst_key", core_key, 80'(0));
    chk("rst_jobs", 80'({jobs1, jobs0}), 80'(0));
    @(negedge clk);
    reset_n = 1'b1;
    m_last = 1; m_jobs[0] = 0; m_jobs[1] = 0;
  endtask

  // Follows one job from grant to ack release and checks it against the model.
  task automatic do_job(input string tag, input int g, input logic [79:0] ekey,
                        input logic [63:0] ept, input logic [63:0] ect, input logic eerr,
                        input int en, input int sdly, input bit drop_early, input bit reraise);
    int n;
    n = 0;
    while (!core_start && n < 100) begin @(negedge clk); n++; end
    chk({tag, "_gnt_dly"}, 80'(n), 80'(sdly));
    if (!core_start) return;
    chk({tag, "_busy"}, 80'(busy), 80'(1));
    chk({tag, "_key"}, core_key, ekey);
    chk({tag, "_pt"}, 80'(core_pt), 80'(ept));
    if (drop_early) req[g] = 1'b0;
    @(negedge clk);
    n = 1;
    chk({tag, "_start_pulse"}, 80'(core_start), 80'(0));
    while (ack == 2'b00 && n < 200) begin @(negedge clk); n++; end
    chk({tag, "_lat"}, 80'(n), 80'(en));
    chk({tag, "_ack"}, 80'(ack), 80'((g == 0) ? 2'b01 : 2'b10));
    chk({tag, "_ct"}, 80'(rsp_ct), 80'(ect));
    chk({tag, "_err"}, 80'(rsp_err), 80'(eerr));
    if (!eerr) m_jobs[g] = (m_jobs[g] + 1) % (1 << CW);
    chk({tag, "_jobs0"}, 80'(jobs0), 80'(m_jobs[0]));
    chk({tag, "_jobs1"}, 80'(jobs1), 80'(m_jobs[1]));
    req[g] = 1'b0;
    @(negedge clk);
    chk({tag, "_ack_fall"}, 80'(ack), 80'(0));
    chk({tag, "_idle"}, 80'(busy), 80'(0));
    chk({tag, "_ct_hold"}, 80'(rsp_ct), 80'(ect));
    m_last = g;
    if (reraise) req[g] = 1'b1;
  endtask

  typedef struct {
    bit          rst;
    logic [1:0]  rq;
    logic [79:0] k0, k1;
    logic [63:0] p0, p1;
    int          mode, lat, g;
    logic [63:0] ct;
    logic        err;
    int          n;
    bit          reraise;
  } vec_t;

  function automatic vec_t mk(bit rst, logic [1:0] rq, logic [79:0] k0, logic [63:0] p0,
                              logic [79:0] k1, logic [63:0] p1, int mode, int lat, int g,
                              logic [63:0] ct, logic err, int n, bit reraise);
    vec_t v;
    v.rst = rst; v.rq = rq; v.k0 = k0; v.p0 = p0; v.k1 = k1; v.p1 = p1;
    v.mode = mode; v.lat = lat; v.g = g; v.ct = ct; v.err = err; v.n = n; v.reraise = reraise;
    return v;
  endfunction

  vec_t        vt[14];
  logic [79:0] ff80, ka, kb, kc, rk;
  logic [63:0] ff64, pa, rp, rct;
  logic [1:0]  rq;
  int          lat, g1st, gg;
  logic        rerr;

  initial begin
    ff80 = '1; ff64 = '1;
    ka = 80'h0123_4567_89AB_CDEF_1357;
    kb = 80'hA5A5_5A5A_F00F_0FF0_C3C3;
    kc = 80'h8000_0000_0000_0000_0001;
    pa = 64'hFEDC_BA98_7654_3210;

    // single job, contention from reset, six-job fairness, timeout, stale done,
    // done exactly at watchdog terminal count, done one cycle too late, minimum latency
    vt[0]  = mk(1, 2'b01, '0, '0, '0, '0, 0, 31, 0, 64'h5579C1387B228445, 0, 33, 0);
    vt[1]  = mk(1, 2'b11, ff80, ff64, ff80, ff64, 0, 31, 0, 64'h3333DCD3213210D2, 0, 33, 0);
    vt[2]  = mk(0, 2'b00, ff80, ff64, ff80, ff64, 0, 31, 1, 64'h3333DCD3213210D2, 0, 33, 0);
    vt[3]  = mk(1, 2'b11, '0, '0, ff80, ff64, 0, 5, 0, 64'h5579C1387B228445, 0, 7, 1);
    vt[4]  = mk(0, 2'b00, '0, '0, ff80, ff64, 0, 5, 1, 64'h3333DCD3213210D2, 0, 7, 1);
    vt[5]  = mk(0, 2'b00, '0, '0, ff80, ff64, 0, 5, 0, 64'h5579C1387B228445, 0, 7, 1);
    vt[6]  = mk(0, 2'b00, '0, '0, ff80, ff64, 0, 5, 1, 64'h3333DCD3213210D2, 0, 7, 1);
    vt[7]  = mk(0, 2'b00, '0, '0, ff80, ff64, 0, 5, 0, 64'h5579C1387B228445, 0, 7, 0);
    vt[8]  = mk(0, 2'b00, '0, '0, ff80, ff64, 0, 5, 1, 64'h3333DCD3213210D2, 0, 7, 0);
    vt[9]  = mk(1, 2'b01, ka, pa, '0, '0, 1, 31, 0, '0, 1, TO + 1, 0);
    vt[10] = mk(0, 2'b01, ka, pa, '0, '0, 2, 31, 0, STALE_CT, 0, 2, 0);
    vt[11] = mk(0, 2'b10, '0, '0, kb, pa, 0, TO - 1, 1, present80(kb, pa), 0, TO + 1, 0);
    vt[12] = mk(0, 2'b10, '0, '0, kb, pa, 0, TO, 1, '0, 1, TO + 1, 0);
    vt[13] = mk(0, 2'b01, kc, ff64, '0, '0, 0, 1, 0, present80(kc, ff64), 0, 3, 0);

    for (int i = 0; i < 14; i++) begin
      if (vt[i].rst) do_reset();
      key0 = vt[i].k0; pt0 = vt[i].p0; key1 = vt[i].k1; pt1 = vt[i].p1;
      core_mode = vt[i].mode; core_lat = vt[i].lat;
      req = req | vt[i].rq;
      gg = vt[i].g;
      do_job($sformatf("v%0d", i), gg, gg ? vt[i].k1 : vt[i].k0, gg ? vt[i].p1 : vt[i].p0,
             vt[i].ct, vt[i].err, vt[i].n, 1, 0, vt[i].reraise);
    end

    // operands changed right after grant must not reach the core
    core_mode = 0; core_lat = 10;
    key0 = ka; pt0 = pa; req = 2'b01;
    @(negedge clk);
    key0 = kb; pt0 = ff64;
    do_job("late_key", 0, ka, pa, present80(ka, pa), 0, 12, 0, 0, 0);

    // requester withdraws during the job: one-cycle ack, counter still advances
    key1 = kc; pt1 = pa; req = 2'b10;
    do_job("drop_mid", 1, kc, pa, present80(kc, pa), 0, 12, 1, 1, 0);

    // asynchronous reset in the middle of WAIT
    core_mode = 1; key0 = kb; pt0 = pa; req = 2'b01;
    @(negedge clk);
    chk("rw_start", 80'(core_start), 80'(1));
    repeat (5) @(negedge clk);
    chk("rw_busy", 80'(busy), 80'(1));
    reset_n = 1'b0; req = '0;
    #1;
    chk("rw_ack", 80'(ack), 80'(0));
    chk("rw_busy0", 80'(busy), 80'(0));
    chk("rw_start0", 80'(core_start), 80'(0));
    chk("rw_key", core_key, 80'(0));
    chk("rw_pt", 80'(core_pt), 80'(0));
    chk("rw_ct", 80'(rsp_ct), 80'(0));
    chk("rw_err", 80'(rsp_err), 80'(0));
    chk("rw_jobs", 80'({jobs1, jobs0}), 80'(0));
    @(negedge clk);
    reset_n = 1'b1;
    m_last = 1; m_jobs[0] = 0; m_jobs[1] = 0;
    core_mode = 0; core_lat = 31; key0 = ka; pt0 = ff64; req = 2'b01;
    do_job("rw_fresh", 0, ka, ff64, present80(ka, ff64), 0, 33, 1, 0, 0);

    // randomized jobs against the round-robin / watchdog model
    for (int it = 0; it < 40; it++) begin
      rq = 2'($urandom_range(1, 3));
      key0 = rnd80(); key1 = rnd80();
      pt0 = {$urandom(), $urandom()}; pt1 = {$urandom(), $urandom()};
      lat = $urandom_range(1, TO + 6);
      core_mode = 0; core_lat = lat;
      req = rq;
      rerr = (lat >= TO);
      g1st = pick(rq);
      for (int s = 0; s < ((rq == 2'b11) ? 2 : 1); s++) begin
        gg = (s == 0) ? g1st : 1 - g1st;
        rk = gg ? key1 : key0;
        rp = gg ? pt1 : pt0;
        rct = rerr ? 64'h0 : present80(rk, rp);
        do_job($sformatf("rnd%0d_%0d", it, s), gg, rk, rp, rct, rerr,
               rerr ? TO + 1 : lat + 2, 1, 0, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
